// File: rtl/alu_flag_branch_unit.sv
// Flag register fed by the ALU result bus, plus a three-state branch resolver
// that evaluates conditions against those flags and advances the program counter.
module alu_flag_branch_unit #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned OFF_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    input  logic [2:0]       alu_op,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_offset,
    output logic             res_valid,
    output logic             res_taken,
    output logic [PC_W-1:0]  pc,
    output logic             z_q,
    output logic             c_q,
    output logic             n_q,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_CS = 3'b011,
        COND_CC = 3'b100,
        COND_MI = 3'b101,
        COND_PL = 3'b110,
        COND_NV = 3'b111
    } cond_t;

    state_t             state_q, state_d;
    cond_t              cond_q, cond_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               taken_q, taken_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic               res_taken_q, res_taken_d;
    logic               z_d, c_d, n_d;
    logic               cond_met;
    logic [PC_W-1:0]    off_ext;

    // Only add/sub produce a meaningful carry; logic and shift ops clear it.
    always_comb begin
        z_d = z_q;
        c_d = c_q;
        n_d = n_q;
        if (alu_valid) begin
            z_d = (alu_result == 8'h00);
            n_d = alu_result[7];
            c_d = (alu_op == 3'b000 || alu_op == 3'b001) ? alu_carry : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            c_q <= c_d;
            n_q <= n_d;
        end
    end

    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            COND_AL: cond_met = 1'b1;
            COND_EQ: cond_met = z_q;
            COND_NE: cond_met = !z_q;
            COND_CS: cond_met = c_q;
            COND_CC: cond_met = !c_q;
            COND_MI: cond_met = n_q;
            COND_PL: cond_met = !n_q;
            COND_NV: cond_met = 1'b0;
            default: cond_met = 1'b0;
        endcase
    end

    assign off_ext = PC_W'($signed(off_q));

    // Results are registered so res_valid appears together with the updated pc.
    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        off_d       = off_q;
        taken_d     = taken_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_taken_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    cond_d  = cond_t'(br_cond);
                    off_d   = br_offset;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                taken_d = cond_met;
                state_d = DONE;
            end
            DONE: begin
                res_valid_d = 1'b1;
                res_taken_d = taken_q;
                if (taken_q) begin
                    pc_d = pc_q + PC_W'(1) + off_ext;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cond_q      <= COND_AL;
            off_q       <= '0;
            taken_q     <= 1'b0;
            pc_q        <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            off_q       <= off_d;
            taken_q     <= taken_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
        end
    end

    assign br_ready  = (state_q == IDLE);
    assign res_valid = res_valid_q;
    assign res_taken = res_taken_q;
    assign pc        = pc_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Scoreboard bench for alu_flag_branch_unit: a reference model predicts each
// resolution at accept time and the monitor compares when res_valid fires.
module tb_alu_flag_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_valid = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_carry = 1'b0;
    logic [2:0] alu_op = 3'b000;
    logic       br_valid = 1'b0;
    logic       br_ready;
    logic [2:0] br_cond = 3'b000;
    logic [7:0] br_offset = 8'h00;
    logic       res_valid;
    logic       res_taken;
    logic [7:0] pc;
    logic       z_q, c_q, n_q;
    logic [7:0] taken_cnt;

    int n_checks = 0;
    int n_errors = 0;

    alu_flag_branch_unit #(.PC_W(8), .OFF_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_result(alu_result), .alu_carry(alu_carry), .alu_op(alu_op),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_offset(br_offset),
        .res_valid(res_valid), .res_taken(res_taken), .pc(pc),
        .z_q(z_q), .c_q(c_q), .n_q(n_q), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       tk;
        logic [7:0] pc;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb[$];

    logic       m_z, m_c, m_n, m_rv;
    logic [1:0] m_phase;
    logic [7:0] m_pc, m_cnt;

    function automatic logic cond_ok(input logic [2:0] c, input logic z, input logic cy, input logic n);
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return n;
            3'd6: return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: flags after this edge are the ones an accepted branch sees.
    always @(posedge clk or negedge rst_n) begin : model
        logic tk;
        if (!rst_n) begin
            m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_rv = 1'b0;
            m_phase = 2'd0; m_pc = 8'h00; m_cnt = 8'h00;
            sb.delete();
        end else begin
            if (alu_valid) begin
                m_z = (alu_result == 8'h00);
                m_n = alu_result[7];
                m_c = (alu_op <= 3'd1) ? alu_carry : 1'b0;
            end
            m_rv = (m_phase == 2'd2);
            case (m_phase)
                2'd0: if (br_valid) begin
                    tk = cond_ok(br_cond, m_z, m_c, m_n);
                    m_pc = tk ? m_pc + 8'd1 + br_offset : m_pc + 8'd1;
                    if (tk && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    sb.push_back('{tk: tk, pc: m_pc, cnt: m_cnt});
                    m_phase = 2'd1;
                end
                2'd1: m_phase = 2'd2;
                default: m_phase = 2'd0;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        check("z_q", z_q, m_z);
        check("c_q", c_q, m_c);
        check("n_q", n_q, m_n);
        check("res_valid", res_valid, m_rv);
        if (rst_n) check("br_ready", br_ready, m_phase == 2'd0);
        if (m_rv && res_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("res_taken", res_taken, e.tk);
                check("pc_at_res", pc, e.pc);
                check("cnt_at_res", taken_cnt, e.cnt);
            end
        end else begin
            check("res_taken_idle", res_taken, 0);
        end
    end

    task automatic alu(input logic [7:0] r, input logic [2:0] op, input logic cy);
        alu_valid = 1'b1; alu_result = r; alu_op = op; alu_carry = cy;
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    // Returns at the negedge after the accept edge (DUT in EVAL).
    task automatic branch(input logic [2:0] c, input logic [7:0] o);
        int unsigned n = 0;
        br_cond = c; br_offset = o; br_valid = 1'b1;
        while (!br_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!br_ready) check("accept_timeout", 0, 1);
        @(negedge clk);
        br_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb.size() != 0 || m_phase != 2'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int rv_seen;
        int rdy_low;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_cnt", taken_cnt, 8'h00);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", br_ready, 1);

        // Subtract to zero, then EQ taken.
        alu(8'h00, 3'b001, 1'b0);
        check("t1_z", z_q, 1);
        branch(3'd1, 8'h04);
        wait_idle();
        check("t1_pc", pc, 8'h05);
        check("t1_cnt", taken_cnt, 8'h01);

        // Carry gating.
        alu(8'h00, 3'b000, 1'b1);
        check("t2_c_add", c_q, 1);
        branch(3'd3, 8'h00);
        wait_idle();
        check("t2_pc_taken", pc, 8'h06);
        alu(8'h00, 3'b010, 1'b1);
        check("t2_c_logic", c_q, 0);
        branch(3'd3, 8'h00);
        wait_idle();
        check("t2_pc_not", pc, 8'h07);

        // Wrap and negative offsets.
        branch(3'd0, 8'hF6);
        wait_idle();
        check("t3_pc_fe", pc, 8'hFE);
        branch(3'd0, 8'h03);
        wait_idle();
        check("t3_wrap", pc, 8'h02);
        branch(3'd0, 8'h1D);
        wait_idle();
        check("t3_pc_20", pc, 8'h20);
        branch(3'd0, 8'hF0);
        wait_idle();
        check("t3_neg", pc, 8'h11);
        branch(3'd7, 8'h40);
        wait_idle();
        check("t3_nv_pc", pc, 8'h12);
        check("t3_nv_cnt", taken_cnt, 8'h06);

        // Flag update in the accept cycle is seen by the branch.
        alu(8'h01, 3'b010, 1'b0);
        check("t4_z0", z_q, 0);
        alu_valid = 1'b1; alu_result = 8'h00; alu_op = 3'b010; alu_carry = 1'b0;
        br_valid = 1'b1; br_cond = 3'd1; br_offset = 8'h02;
        @(negedge clk);
        alu_valid = 1'b0; br_valid = 1'b0;
        wait_idle();
        check("t4_same_cycle", pc, 8'h15);
        // Flag update during EVAL is not seen.
        branch(3'd1, 8'h10);
        alu(8'h80, 3'b010, 1'b0);
        wait_idle();
        check("t4_eval_pc", pc, 8'h26);
        check("t4_z_after", z_q, 0);
        check("t4_n_after", n_q, 1);

        // Continuous br_valid: one resolution per three cycles.
        rv_seen = 0; rdy_low = 0;
        br_cond = 3'd0; br_offset = 8'h00; br_valid = 1'b1;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
            if (res_valid) rv_seen++;
            if (!br_ready) rdy_low++;
        end
        br_valid = 1'b0;
        wait_idle();
        check("t5_res_count", rv_seen, 3);
        check("t5_ready_low", rdy_low, 6);

        // Reset during EVAL discards the branch.
        branch(3'd0, 8'h05);
        #2 rst_n = 1'b0;
        #2;
        check("t5_rst_pc", pc, 8'h00);
        check("t5_rst_flags", {z_q, c_q, n_q}, 3'b000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_rel_ready", br_ready, 1);
        check("t5_rel_pc", pc, 8'h00);

        // Saturation of the taken counter.
        br_cond = 3'd0; br_offset = 8'h00; br_valid = 1'b1;
        repeat (785) @(negedge clk);
        br_valid = 1'b0;
        wait_idle();
        check("t6_sat", taken_cnt, 8'hFF);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_branch_unit.md
Name: alu_flag_branch_unit

Overview:
- Consumer end of the ALU result/flag interface.
- Captures each ALU result into an architectural Z/C/N flag register, computing Z correctly as result==0.
- Resolves conditional branches against those flags through a valid/ready handshake and maintains the program counter.
- Sits between the ALU and fetch in the small CPU datapath.

Parameters:
PC_W, 8, program counter and branch target width
OFF_W, 8, signed branch offset width (OFF_W <= PC_W), sign-extended to PC_W
CNT_W, 8, width of saturating taken-branch counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result present this cycle; update flags
alu_result  input  8  ALU result byte
alu_carry  input  1  ALU carry out
alu_op  input  3  ALU opcode that produced the result (000 add, 001 sub, others logic/shift)
br_valid  input  1  branch request valid
br_ready  output  1  unit can accept a branch
br_cond  input  3  condition: 000 AL, 001 EQ(Z), 010 NE(!Z), 011 CS(C), 100 CC(!C), 101 MI(N), 110 PL(!N), 111 NV
br_offset  input  OFF_W  signed two's-complement offset
res_valid  output  1  one-cycle pulse: branch resolved
res_taken  output  1  branch taken; valid with res_valid
pc  output  PC_W  current program counter
z_q  output  1  zero flag
c_q  output  1  carry flag
n_q  output  1  negative flag
taken_cnt  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async on rst_n low, any state): pc=0, z_q=0, c_q=0, n_q=0, state=IDLE, res_valid=0, res_taken=0, taken_cnt=0, br_ready=1 once released. An in-flight branch is discarded; no res_valid is produced for it.
- Flag update: on a clk edge with alu_valid=1:
  - z_q <= (alu_result==8'h00)
  - n_q <= alu_result[7]
  - c_q <= alu_carry if alu_op is 000 or 001, else 0
- With alu_valid=0, flags hold. Flag updates are accepted in every state.
- FSM states: IDLE, EVAL, DONE.
  - IDLE: br_ready=1. On br_valid&&br_ready, latch br_cond and br_offset, go to EVAL.
  - EVAL: br_ready=0. Evaluate the latched condition against z_q/c_q/n_q as registered at the start of this cycle. That value includes any alu_valid update presented in the accept cycle. Register the taken decision and go to DONE. An alu_valid update during EVAL affects later branches only.
  - DONE: br_ready=0. res_valid=1, res_taken=decision. Go to IDLE.
- Latency: accept at edge T, res_valid high during the cycle after edge T+2, and the next accept is possible at edge T+3. Throughput is one branch per 3 cycles.
- PC update, on the DONE->IDLE edge (pc holds at all other times):
  - Taken: pc <= pc + 1 + sext(offset), modulo 2^PC_W.
  - Not taken: pc <= pc + 1.
  - Wrap-around is silent in both directions.
- res_taken is valid only while res_valid=1. It is 0 at all other times.
- taken_cnt increments on each taken resolution and saturates at all-ones (no wrap).
- AL is always taken; NV is never taken regardless of flags.
- br_valid asserted outside IDLE is ignored and not queued. The requester must hold br_valid until it sees br_ready.
- alu_op values 010..111 force c_q=0 even when alu_carry=1.

Test Plan:
1. Subtract to zero: alu_valid with result=8'h00, op=001, carry=0 -> z_q=1, n_q=0, c_q=0. Then branch EQ, offset=8'h04 at pc=0 -> res_valid two cycles after accept with res_taken=1, pc=8'h05, taken_cnt=1.
2. Carry gating: result=8'h00, op=000, carry=1 (FF+01) -> z_q=1, c_q=1; CS branch taken. Then result=8'h00, op=010, carry=1 -> c_q=0; CS branch not taken, pc advances by 1.
3. Wrap and negative offset:
   - pc=8'hFE, AL with offset +3 -> pc=8'h02.
   - pc=8'h20, AL with offset 8'hF0 (-16) -> pc=8'h11.
   - NV -> res_taken=0, pc+1.
4. Same-cycle hazard:
   - Flags hold Z=0. In the accept cycle of an EQ branch, drive alu_valid with result=0 -> branch taken.
   - During EVAL of a later EQ branch, drive alu_valid with result=8'h80 -> that branch uses the old Z; z_q=0 and n_q=1 afterwards.
5. Handshake and reset:
   - br_valid held continuously -> br_ready=0 in EVAL/DONE, exactly one resolution per 3 cycles.
   - rst_n pulsed low during EVAL -> no res_valid, pc=0, flags 0, br_ready=1 after release.
6. Saturation: 260 taken AL branches -> taken_cnt stops at 8'hFF.
